regfile_bypass_sb: RTL and testbench

REGFILE_BYPASS_SB -- requirements
Module: regfile_bypass_sb

---
 rtl/regfile_bypass_sb.sv | 74 +++++++
 tb/tb_regfile_bypass_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_sb.sv
// Register file with write-first bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never marked busy.
module regfile_bypass_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wb_hit;
  logic             iss_hit;

  assign wb_hit  = wb_en  && (wb_addr  != '0);
  assign iss_hit = iss_en && (iss_addr != '0);

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  // Flush beats issue; issue beats a same-address writeback so the later
  // producer stays tracked.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_hit)  busy_nxt[wb_addr]  = 1'b0;
      if (iss_hit) busy_nxt[iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wb_hit) regs[wb_addr] <= wb_data;
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  // Each read port sees the same-cycle writeback value and hazard resolution.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          bypass;
    assign a      = rd_addr[g*AW +: AW];
    assign bypass = wb_hit && (wb_addr == a);
    assign rd_data[g*XLEN +: XLEN] = (a == '0) ? '0 : (bypass ? wb_data : regs[a]);
    assign rd_busy[g] = busy[a] && !(wb_en && (wb_addr == a));
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: default 32x32 two-port instance driven from a
// vector table, plus a 16x64 three-port instance for the wide bypass case.
module tb_regfile_bypass_sb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb_en, iss_en, flush;
  logic [4:0]  wb_addr, iss_addr;
  logic [31:0] wb_data;
  logic [5:0]  busy_cnt;

  regfile_bypass_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  // Wide instance: NRD=3, XLEN=64, NREGS=16
  logic [11:0]  w_rd_addr;
  logic [191:0] w_rd_data;
  logic [2:0]   w_rd_busy;
  logic         w_wb_en, w_iss_en, w_flush;
  logic [3:0]   w_wb_addr, w_iss_addr;
  logic [63:0]  w_wb_data;
  logic [4:0]   w_busy_cnt;

  regfile_bypass_sb #(.XLEN(64), .NREGS(16), .NRD(3)) dut_w (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data), .iss_en(w_iss_en),
    .iss_addr(w_iss_addr), .flush(w_flush), .busy_cnt(w_busy_cnt)
  );

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        b0, b1;
    logic [5:0]  cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t        vecs[NV];
  logic [71:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] rnd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ie, input logic [4:0] ia, input logic fl,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic b0, input logic b1, input logic [5:0] cnt);
    vec_t v;
    v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
    v.iss_en = ie; v.iss_addr = ia; v.flush = fl;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive_idle();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  // Combinational outputs checked mid-cycle, busy_cnt checked after the edge.
  task automatic apply(input vec_t v, input int idx);
    logic [71:0] e;
    @(negedge clk);
    wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
    iss_en = v.iss_en; iss_addr = v.iss_addr; flush = v.flush;
    rd_addr = {v.a1, v.a0};
    exp_q.push_back({v.d0, v.d1, v.b0, v.b1, v.cnt});
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d rd_data0", idx), 128'(rd_data[31:0]),  128'(e[71:40]));
    chk($sformatf("v%0d rd_data1", idx), 128'(rd_data[63:32]), 128'(e[39:8]));
    chk($sformatf("v%0d rd_busy0", idx), 128'(rd_busy[0]),     128'(e[7]));
    chk($sformatf("v%0d rd_busy1", idx), 128'(rd_busy[1]),     128'(e[6]));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d busy_cnt", idx), 128'(busy_cnt), 128'(e[5:0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rnd = $urandom_range(32'h7fff_ffff, 1);
    //             we   wa     wd             ie   ia     fl   a0     a1     d0             d1             b0   b1   cnt
    vecs[0]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd0,  5'd31, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0);
    vecs[1]  = mk(1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0,  1'b0, 5'd5,  5'd6,  32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 6'd0);
    vecs[2]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  1'b0, 1'b0, 6'd0);
    vecs[3]  = mk(1'b1, 5'd0,  32'hFFFFFFFF,  1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 6'd0);
    vecs[4]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 5'd3,  5'd7,  32'h0,         32'h0,         1'b0, 1'b0, 6'd1);
    vecs[5]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b0, 5'd3,  5'd7,  32'h0,         32'h0,         1'b1, 1'b0, 6'd2);
    vecs[6]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd7,  5'd3,  32'h0,         32'h0,         1'b1, 1'b1, 6'd2);
    vecs[7]  = mk(1'b1, 5'd7,  32'h77,        1'b0, 5'd0,  1'b0, 5'd7,  5'd3,  32'h77,        32'h0,         1'b0, 1'b1, 6'd1);
    vecs[8]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  32'h77,        32'h77,        1'b0, 1'b0, 6'd1);
    vecs[9]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  1'b0, 5'd9,  5'd3,  32'h0,         32'h0,         1'b0, 1'b1, 6'd2);
    vecs[10] = mk(1'b1, 5'd9,  32'h11,        1'b1, 5'd9,  1'b0, 5'd9,  5'd9,  32'h11,        32'h11,        1'b0, 1'b0, 6'd2);
    vecs[11] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd9,  5'd3,  32'h11,        32'h0,         1'b1, 1'b1, 6'd2);
    vecs[12] = mk(1'b1, 5'd12, 32'hC0FFEE,    1'b1, 5'd4,  1'b1, 5'd4,  5'd12, 32'h0,         32'hC0FFEE,    1'b0, 1'b0, 6'd0);
    vecs[13] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd12, 5'd9,  32'hC0FFEE,    32'h11,        1'b0, 1'b0, 6'd0);
    vecs[14] = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 5'd5,  5'd3,  32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 6'd1);
    vecs[15] = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 5'd5,  5'd3,  32'hDEADBEEF,  32'h0,         1'b0, 1'b1, 6'd1);
    vecs[16] = mk(1'b1, 5'd20, rnd,           1'b0, 5'd0,  1'b0, 5'd20, 5'd3,  rnd,           32'h0,         1'b0, 1'b1, 6'd1);
    vecs[17] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd20, 5'd0,  rnd,           32'h0,         1'b0, 1'b0, 6'd1);

    drive_idle();
    rd_addr = '0;
    w_wb_en = 1'b0; w_wb_addr = '0; w_wb_data = '0;
    w_iss_en = 1'b0; w_iss_addr = '0; w_flush = 1'b0; w_rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Post-reset sweep of every address on both ports
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("reset x%0d rd_data0", a), 128'(rd_data[31:0]), 128'h0);
      chk($sformatf("reset x%0d rd_data1", a), 128'(rd_data[63:32]), 128'h0);
      chk($sformatf("reset x%0d rd_busy", a), 128'(rd_busy), 128'h0);
    end
    chk("reset busy_cnt", 128'(busy_cnt), 128'h0);
    chk("reset wide busy_cnt", 128'(w_busy_cnt), 128'h0);

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Issue x12 (x3 already busy), then asynchronous reset between edges
    @(negedge clk);
    drive_idle();
    iss_en = 1'b1; iss_addr = 5'd12; rd_addr = {5'd3, 5'd12};
    @(posedge clk);
    #1;
    chk("pre-reset busy_cnt", 128'(busy_cnt), 128'd2);
    #2;
    iss_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("async reset busy_cnt", 128'(busy_cnt), 128'h0);
    chk("async reset x12 data", 128'(rd_data[31:0]), 128'h0);
    chk("async reset x3 busy", 128'(rd_busy[1]), 128'h0);
    rd_addr = {5'd20, 5'd5};
    #1;
    chk("async reset x5 data", 128'(rd_data[31:0]), 128'h0);
    chk("async reset x20 data", 128'(rd_data[63:32]), 128'h0);

    // First edge after release must not lose the write or the issue
    @(negedge clk);
    rst = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
    iss_en = 1'b1; iss_addr = 5'd6;
    @(posedge clk);
    #1;
    chk("first edge busy_cnt", 128'(busy_cnt), 128'd1);
    @(negedge clk);
    drive_idle();
    rd_addr = {5'd6, 5'd5};
    #1;
    chk("first edge x5 data", 128'(rd_data[31:0]), 128'h1234_5678);
    chk("first edge x6 busy", 128'(rd_busy[1]), 128'h1);

    // Wide instance: write-first bypass on two ports, x0 on the third
    @(negedge clk);
    w_wb_en = 1'b1; w_wb_addr = 4'd5; w_wb_data = 64'hDEADBEEF_CAFEF00D;
    w_rd_addr = {4'd5, 4'd0, 4'd5};
    #1;
    chk("wide bypass port0", 128'(w_rd_data[63:0]),    128'(64'hDEADBEEF_CAFEF00D));
    chk("wide bypass port1", 128'(w_rd_data[127:64]),  128'h0);
    chk("wide bypass port2", 128'(w_rd_data[191:128]), 128'(64'hDEADBEEF_CAFEF00D));
    @(negedge clk);
    w_wb_en = 1'b0; w_wb_data = '0;
    w_rd_addr = {4'd5, 4'd5, 4'd5};
    #1;
    chk("wide held port0", 128'(w_rd_data[63:0]),    128'(64'hDEADBEEF_CAFEF00D));
    chk("wide held port1", 128'(w_rd_data[127:64]),  128'(64'hDEADBEEF_CAFEF00D));
    chk("wide held port2", 128'(w_rd_data[191:128]), 128'(64'hDEADBEEF_CAFEF00D));
    chk("wide busy_cnt", 128'(w_busy_cnt), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
